// File: rtl/pg_carry_sum_unit.sv
// pg_carry_sum_unit: the back end of the prefix adder. It takes N-bit
// propagate/generate words and a carry-in, and resolves the carries one
// CHUNK-bit slice per cycle. It produces the sum, the carry-out and the
// signed overflow flag.
//
// Handshake: a transfer happens only on a clock edge where valid and ready
// are both high. The producer may drop in_valid before it is accepted, and
// the consumer may toggle out_ready freely. Once out_valid is high, S, cout
// and ovf stay stable until out_ready takes them.
module pg_carry_sum_unit #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] P,
  input  logic [N-1:0] G,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         cout,
  output logic         ovf
);

  localparam int NCH = N / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (CHUNK < 1 || (N % CHUNK) != 0) begin : g_bad_chunk
      $error("pg_carry_sum_unit: CHUNK must divide N evenly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [N-1:0]    p_q, g_q;
  logic [CHUNK-1:0] p_chunk, g_chunk, s_chunk;
  logic            c_top, c_below_top;
  logic            last_chunk;
  logic            accept;

  assign last_chunk = (idx_q == IW'(NCH - 1));
  assign accept     = (state_q == IDLE) && in_valid && in_ready;

  // Pick the latched P/G slice that this RUN cycle resolves.
  always_comb begin
    p_chunk = '0;
    g_chunk = '0;
    for (int c = 0; c < NCH; c++) begin
      if (idx_q == IW'(c)) begin
        p_chunk = p_q[c*CHUNK +: CHUNK];
        g_chunk = g_q[c*CHUNK +: CHUNK];
      end
    end
  end

  // Ripple the carry through the slice. The carry into the slice's top bit
  // is kept, because the overflow flag needs c[N-1] on the last chunk.
  always_comb begin
    logic c_run;
    c_run       = carry_q;
    c_below_top = carry_q;
    s_chunk     = '0;
    for (int j = 0; j < CHUNK; j++) begin
      s_chunk[j]  = p_chunk[j] ^ c_run;
      c_below_top = c_run;
      c_run       = g_chunk[j] | (p_chunk[j] & c_run);
    end
    c_top = c_run;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs. in_ready is masked while rst is high.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) state_d = RUN;
      end
      RUN: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, chunk index, running carry and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      g_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      S       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      p_q     <= P;
      g_q     <= G;
      carry_q <= cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      carry_q <= c_top;
      idx_q   <= idx_q + IW'(1);
      for (int c = 0; c < NCH; c++) begin
        if (idx_q == IW'(c)) S[c*CHUNK +: CHUNK] <= s_chunk;
      end
      if (last_chunk) begin
        cout <= c_top;
        ovf  <= c_top ^ c_below_top;
      end
    end
  end

endmodule

// File: tb/tb_pg_carry_sum_unit.sv
// Testbench for pg_carry_sum_unit. It runs directed vectors on the
// CHUNK=8 instance, then compares random operands on CHUNK=1/4/32
// instances against a plain A+B+cin model.
module tb_pg_carry_sum_unit;

  localparam int N = 32;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT, CHUNK=8.
  logic          in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [N-1:0]  P = '0, G = '0;
  logic          in_ready, out_valid, cout, ovf;
  logic [N-1:0]  S;

  pg_carry_sum_unit #(.N(N), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .G(G), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .cout(cout), .ovf(ovf)
  );

  // Sweep DUTs: CHUNK=1, 4 and 32 share one stimulus and always take results.
  logic          sw_valid = 1'b0, sw_cin = 1'b0;
  logic [N-1:0]  sw_p = '0, sw_g = '0;
  logic          sw_ir[3], sw_ov[3], sw_cout[3], sw_ovf[3];
  logic [N-1:0]  sw_s[3];
  int            sw_nch[3] = '{32, 8, 1};

  pg_carry_sum_unit #(.N(N), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[0]),
    .P(sw_p), .G(sw_g), .cin(sw_cin), .out_valid(sw_ov[0]), .out_ready(1'b1),
    .S(sw_s[0]), .cout(sw_cout[0]), .ovf(sw_ovf[0])
  );
  pg_carry_sum_unit #(.N(N), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[1]),
    .P(sw_p), .G(sw_g), .cin(sw_cin), .out_valid(sw_ov[1]), .out_ready(1'b1),
    .S(sw_s[1]), .cout(sw_cout[1]), .ovf(sw_ovf[1])
  );
  pg_carry_sum_unit #(.N(N), .CHUNK(32)) u_c32 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[2]),
    .P(sw_p), .G(sw_g), .cin(sw_cin), .out_valid(sw_ov[2]), .out_ready(1'b1),
    .S(sw_s[2]), .cout(sw_cout[2]), .ovf(sw_ovf[2])
  );

  // Scoreboard counters.
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait up to 50 cycles for the main DUT to show in_ready.
  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  // One directed operation on the main DUT. The task checks the latency
  // and the result. It can scramble P/G during RUN and hold off out_ready
  // for a number of cycles.
  task automatic run_op(input string tag, input logic [N-1:0] p, input logic [N-1:0] g,
                        input logic ci, input logic [N-1:0] es, input logic ec,
                        input logic eo, input bit scramble, input int hold);
    int lat;
    wait_ready(tag);
    P = p; G = g; cin = ci; in_valid = 1'b1;
    @(negedge clk);               // accepting edge T has passed
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (scramble) begin
        P = $urandom; G = $urandom; cin = ~cin;
      end
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"},  64'(lat),  64'd4);
    check({tag, "_s"},    64'(S),    64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"},  64'(ovf),  64'(eo));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_ov"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_s"},  64'(S),         64'(es));
      check({tag, "_hold_c"},  64'({cout, ovf}), 64'({ec, eo}));
      check({tag, "_hold_ir"}, 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_ov"}, 64'(out_valid), 64'd0);
    check({tag, "_post_ir"}, 64'(in_ready),  64'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a, b, es;
    logic         ci, ec, eo;
    logic [N:0]   sum;
    int           lat[3];
    bit           seen[3];
    int           t;

    // Reset state.
    @(negedge clk);
    check("rst_s",   64'(S),         64'd0);
    check("rst_co",  64'({cout, ovf}), 64'd0);
    check("rst_ov",  64'(out_valid), 64'd0);
    check("rst_ir",  64'(in_ready),  64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ir", 64'(in_ready),  64'd1);

    // Directed vectors with hand-computed results.
    run_op("ffff_p1", 32'hFFFFFFFE, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 0);
    run_op("max_p1",  32'h7FFFFFFE, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 0);
    run_op("cin_only", 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 0);
    run_op("ripple",  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 0);
    run_op("neg_ovf", 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 0);
    // Backpressure with P/G scrambled during RUN: 0x0000FFFF + 1.
    run_op("bp",      32'h0000FFFE, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b1, 5);

    // Asynchronous reset during RUN when idx=2. Chunk 0 of S is already 0x0F.
    wait_ready("rst_run");
    P = 32'h0F0F0F0F; G = '0; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);               // after T: idx 0
    in_valid = 1'b0;
    @(negedge clk);               // after T+1: idx 1
    @(negedge clk);               // after T+2: idx 2
    check("pre_rst_s", 64'(S[7:0]), 64'h0F);
    #2 rst = 1'b1;
    #1;
    check("arst_s",  64'(S),         64'd0);
    check("arst_co", 64'({cout, ovf}), 64'd0);
    check("arst_ov", 64'(out_valid), 64'd0);
    check("arst_ir", 64'(in_ready),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ir",  64'(in_ready),  64'd1);
    check("rel_ov",  64'(out_valid), 64'd0);
    @(negedge clk);
    run_op("after_rst", 32'h7FFFFFFE, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 0);

    // Random sweep across CHUNK=1, 4 and 32 against the A+B+cin model.
    for (int v = 0; v < 1000; v++) begin
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom_range(0, 1));
      sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
      es  = sum[N-1:0];
      ec  = sum[N];
      eo  = (a[N-1] == b[N-1]) && (es[N-1] != a[N-1]);
      t = 0;
      while (!(sw_ir[0] && sw_ir[1] && sw_ir[2]) && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t == 50) check("sw_ready", 64'd0, 64'd1);
      sw_p = a ^ b; sw_g = a & b; sw_cin = ci; sw_valid = 1'b1;
      @(negedge clk);
      sw_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        seen[k] = 1'b0;
        lat[k]  = 0;
      end
      t = 0;
      while (!(seen[0] && seen[1] && seen[2]) && t < 60) begin
        for (int k = 0; k < 3; k++) begin
          if (!seen[k] && sw_ov[k]) begin
            seen[k] = 1'b1;
            lat[k]  = t;
            check($sformatf("sw%0d_v%0d_s", k, v),    64'(sw_s[k]),    64'(es));
            check($sformatf("sw%0d_v%0d_cout", k, v), 64'(sw_cout[k]), 64'(ec));
            check($sformatf("sw%0d_v%0d_ovf", k, v),  64'(sw_ovf[k]),  64'(eo));
            check($sformatf("sw%0d_v%0d_lat", k, v),  64'(lat[k]),     64'(sw_nch[k]));
          end
        end
        if (!(seen[0] && seen[1] && seen[2])) begin
          @(negedge clk);
          t++;
        end
      end
      for (int k = 0; k < 3; k++)
        if (!seen[k]) check($sformatf("sw%0d_v%0d_timeout", k, v), 64'd0, 64'd1);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pg_carry_sum_unit.md
Name: pg_carry_sum_unit

Overview:
- Back end of the prefix-adder datapath: consumes N-bit Propagate/Generate words from the PG generation stage plus a carry-in.
- Resolves carries sequentially, CHUNK bits per cycle, and produces the N-bit sum, carry-out and signed overflow.
- Valid/ready handshake on both sides, so the ALU toplevel can stall it.
- Trades latency for area against a full parallel prefix tree.

Parameters:
- N, 32, word width in bits; bit 1 = LSB, bit N = MSB.
- CHUNK, 8, bits resolved per RUN cycle; must divide N evenly (elaboration error otherwise).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset.
- in_valid  input  1  P/G/cin present.
- in_ready  output  1  unit can accept an operand.
- P  input  N  propagate word (A^B).
- G  input  N  generate word (A&B).
- cin  input  1  carry into bit 1.
- out_valid  output  1  S/cout/ovf valid.
- out_ready  input  1  consumer takes result.
- S  output  N  sum.
- cout  output  1  carry out of bit N.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Interface rule (already decided): one clock; reset is asynchronous and active-high.
- Reset (async, rst=1):
  - State = IDLE, chunk index = 0, carry register = 0.
  - Outputs: S=0, cout=0, ovf=0, out_valid=0; in_ready=0 while rst is high.
  - Operand latches cleared.
  - Reset asserted mid-RUN or in DONE aborts the operation. The result is lost and no out_valid pulse occurs.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 (after rst deasserts).
  - When in_valid & in_ready: latch P, G; carry reg = cin; idx = 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle handles bits k = idx*CHUNK+1 .. idx*CHUNK+CHUNK.
  - Carry chain across the chunk: c[k] = G[k] | (P[k] & c[k-1]), with c[k-1] for the chunk's first bit = carry reg.
  - Sum: S[k] = P[k] ^ c[k-1]. Written into the S register only for this chunk's bits; other bits untouched.
  - Carry reg <= c of the chunk's top bit; idx <= idx+1.
  - On the last chunk (idx = N/CHUNK-1):
    - cout <= c[N]; ovf <= c[N] ^ c[N-1].
    - c[N-1] comes from the current chunk, or from the carry reg when CHUNK=1.
    - Go to DONE.
- DONE:
  - out_valid=1.
  - S, cout, ovf are held stable until the handshake completes.
  - On out_valid & out_ready: go to IDLE, out_valid=0 next cycle.
  - No same-cycle accept of a new operand (in_ready=0 in DONE).
- Latency: handshake accepted at edge T → out_valid high after edge T+N/CHUNK. With CHUNK=N, one RUN cycle.
- Throughput: one result per N/CHUNK+2 cycles when out_ready=1.
- Outputs S/cout/ovf are registered and change only during RUN or reset. Value between operations = last result.
- Inputs P/G/cin are ignored outside the IDLE accept cycle; changing them during RUN has no effect.
- in_valid may drop without acceptance (no obligation); out_ready may toggle freely. Only the valid&ready cycle is a transfer.
- No X-propagation from unused bits; every bit of S is written exactly once per operation.

Test Plan:
- N=32, CHUNK=8: P=0xFFFFFFFE, G=0x00000001, cin=0 (A=0xFFFFFFFF, B=1) → out_valid at edge T+4; S=0x00000000, cout=1, ovf=0.
- P=0x7FFFFFFE, G=0x00000001, cin=0 (A=0x7FFFFFFF, B=1) → S=0x80000000, cout=0, ovf=1.
- P=0, G=0, cin=1 → S=0x00000001, cout=0, ovf=0; then P=0xFFFFFFFF, G=0, cin=1 → S=0x00000000, cout=1, ovf=0 (full carry ripple across all chunks).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, S/cout/ovf constant, in_ready=0. Raise out_ready → one transfer, in_ready=1 next cycle. Toggle P/G during RUN → result unchanged.
- Assert rst asynchronously (between edges) during RUN idx=2 → S=0, out_valid=0, in_ready=0 immediately. After release: IDLE, in_ready=1, and a new operand completes correctly.
- Parameter sweep CHUNK ∈ {1, 4, 32} with 1000 random A, B, cin (P=A^B, G=A&B) → S, cout and ovf match the golden model A+B+cin; latency = N/CHUNK cycles.
